// File: rtl/nebula_vc_buffer.sv
// Multi-VC show-ahead input buffer: NUM_VCS FIFOs share one storage array and
// return one credit per popped flit. Optional sticky error status: NEBULA_VCBUF_ERR_STATUS_EN.
module nebula_vc_buffer #(
   parameter int NUM_VCS    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4,
   parameter int AF_THRESH  = DEPTH - 1,
   localparam int VW = $clog2(NUM_VCS),
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [VW-1:0]             wr_vc,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   output logic                      wr_accept,
   input  logic                      rd_en,
   input  logic [VW-1:0]             rd_vc,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      rd_valid,
   output logic [NUM_VCS-1:0]        vc_empty,
   output logic [NUM_VCS-1:0]        vc_full,
   output logic [NUM_VCS-1:0]        vc_almost_full,
   output logic [NUM_VCS*CW-1:0]     vc_count,
   output logic [NUM_VCS-1:0]        credit_rtn,
   input  logic                      err_clr,
   output logic [NUM_VCS-1:0]        err_ovf,
   output logic [NUM_VCS-1:0]        err_udf
);

   localparam int AW = $clog2(NUM_VCS * DEPTH);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;
   typedef logic [AW-1:0] addr_t;

   localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);
   localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
   localparam cnt_t CNT_AF   = cnt_t'(AF_THRESH);

   ptr_t wr_ptr_q [NUM_VCS];
   ptr_t wr_ptr_d [NUM_VCS];
   ptr_t rd_ptr_q [NUM_VCS];
   ptr_t rd_ptr_d [NUM_VCS];
   cnt_t count_q  [NUM_VCS];
   cnt_t count_d  [NUM_VCS];

   logic [NUM_VCS-1:0]    credit_q;
   logic [DATA_WIDTH-1:0] mem_q [NUM_VCS*DEPTH];

   logic [NUM_VCS-1:0] wr_sel, rd_sel, wr_acc, rd_acc;
   addr_t              wr_addr, rd_addr;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
   endfunction

   function automatic addr_t slot(input int v, input ptr_t p);
      return addr_t'(v * DEPTH) + addr_t'(p);
   endfunction

   // Out-of-range VC indices match no select bit, so they are ignored naturally.
   always_comb begin
      wr_sel         = '0;
      rd_sel         = '0;
      vc_empty       = '0;
      vc_full        = '0;
      vc_almost_full = '0;
      vc_count       = '0;
      for (int v = 0; v < NUM_VCS; v++) begin
         wr_sel[v]               = wr_en && (wr_vc == VW'(v));
         rd_sel[v]               = rd_vc == VW'(v);
         vc_empty[v]             = count_q[v] == '0;
         vc_full[v]              = count_q[v] == CNT_FULL;
         vc_almost_full[v]       = count_q[v] >= CNT_AF;
         vc_count[v*CW +: CW]    = count_q[v];
      end
   end

   // A full VC still takes a write when the same VC is popped this cycle;
   // an empty VC never bypasses a same-cycle write to the read side.
   always_comb begin
      rd_acc = '0;
      wr_acc = '0;
      for (int v = 0; v < NUM_VCS; v++) begin
         rd_acc[v] = rd_en && rd_sel[v] && !vc_empty[v];
         wr_acc[v] = wr_sel[v] && (!vc_full[v] || rd_acc[v]);
      end
   end

   assign wr_accept = |wr_acc;
   assign rd_valid  = |(rd_sel & ~vc_empty);

   always_comb begin
      wr_addr = '0;
      rd_addr = '0;
      for (int v = 0; v < NUM_VCS; v++) begin
         if (wr_sel[v]) wr_addr = slot(v, wr_ptr_q[v]);
         if (rd_sel[v]) rd_addr = slot(v, rd_ptr_q[v]);
      end
   end

   assign rd_data = rd_valid ? mem_q[rd_addr] : '0;

   always_comb begin
      for (int v = 0; v < NUM_VCS; v++) begin
         wr_ptr_d[v] = wr_acc[v] ? ptr_inc(wr_ptr_q[v]) : wr_ptr_q[v];
         rd_ptr_d[v] = rd_acc[v] ? ptr_inc(rd_ptr_q[v]) : rd_ptr_q[v];
         case ({wr_acc[v], rd_acc[v]})
            2'b10:   count_d[v] = count_q[v] + cnt_t'(1);
            2'b01:   count_d[v] = count_q[v] - cnt_t'(1);
            default: count_d[v] = count_q[v];
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int v = 0; v < NUM_VCS; v++) begin
            wr_ptr_q[v] <= '0;
            rd_ptr_q[v] <= '0;
            count_q[v]  <= '0;
         end
         credit_q <= '0;
      end else begin
         for (int v = 0; v < NUM_VCS; v++) begin
            wr_ptr_q[v] <= wr_ptr_d[v];
            rd_ptr_q[v] <= rd_ptr_d[v];
            count_q[v]  <= count_d[v];
         end
         credit_q <= rd_acc;
      end
   end

   // NOTE: storage has no reset; counts gate visibility, so stale data is never read.
   always_ff @(posedge clk) begin
      if (wr_accept) mem_q[wr_addr] <= wr_data;
   end

   assign credit_rtn = credit_q;

`ifdef NEBULA_VCBUF_ERR_STATUS_EN
   logic [NUM_VCS-1:0] err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

   // Clear first, then OR in new events so a same-cycle set wins.
   assign err_ovf_d = (err_clr ? '0 : err_ovf_q) | (wr_sel & ~wr_acc & vc_full);
   assign err_udf_d = (err_clr ? '0 : err_udf_q) | ({NUM_VCS{rd_en}} & rd_sel & vc_empty);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_ovf_q <= '0;
         err_udf_q <= '0;
      end else begin
         err_ovf_q <= err_ovf_d;
         err_udf_q <= err_udf_d;
      end
   end

   assign err_ovf = err_ovf_q;
   assign err_udf = err_udf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_ovf        = '0;
   assign err_udf        = '0;
`endif

endmodule

// File: doc/nebula_vc_buffer.md
Name: nebula_vc_buffer

Overview:
Multi-virtual-channel input buffer for the router input port. Holds NUM_VCS independent show-ahead FIFOs in one storage array. One write and one read are allowed per cycle, each to a selected VC. Each accepted read produces a registered per-VC credit-return pulse for the upstream credit counter, and the block reports per-VC occupancy to the VC/switch allocators.

Parameters:
- NUM_VCS, 4, number of virtual channels (>=2).
- DATA_WIDTH, 64, flit width in bits.
- DEPTH, 4, entries per VC (>=2; need not be a power of two).
- AF_THRESH, DEPTH-1, vc_almost_full asserts when count >= AF_THRESH.
- Derived: VW = $clog2(NUM_VCS); PW = $clog2(DEPTH); CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- wr_en  in  1  write request.
- wr_vc  in  VW  target VC for the write.
- wr_data  in  DATA_WIDTH  flit to write.
- wr_accept  out  1  combinational; the write is taken this cycle.
- rd_en  in  1  read (pop) request.
- rd_vc  in  VW  VC to read; also selects rd_data.
- rd_data  out  DATA_WIDTH  head flit of rd_vc (show-ahead); 0 when that VC is empty.
- rd_valid  out  1  rd_vc is non-empty.
- vc_empty  out  NUM_VCS  per-VC empty.
- vc_full  out  NUM_VCS  per-VC full.
- vc_almost_full  out  NUM_VCS  per-VC count >= AF_THRESH.
- vc_count  out  NUM_VCS*CW  per-VC count; VC i occupies bits [i*CW +: CW].
- credit_rtn  out  NUM_VCS  registered one-hot pulse, one cycle after an accepted read.
- err_clr  in  1  clears the sticky error flags.
- err_ovf  out  NUM_VCS  sticky: write attempted to a full VC.
- err_udf  out  NUM_VCS  sticky: read attempted from an empty VC.

Behaviour:
- Storage: NUM_VCS*DEPTH entries. VC i uses entries i*DEPTH .. i*DEPTH+DEPTH-1. Storage is not reset.
- Per-VC state: wr_ptr[PW], rd_ptr[PW], count[CW]. Pointers wrap from DEPTH-1 to 0.
- Reset, asynchronous while rst=1: all pointers, counts, credit_rtn, err_ovf and err_udf go to 0. Resulting outputs: vc_empty all 1, vc_full 0, rd_valid 0, rd_data 0, wr_accept 0 unless its accept conditions hold.
- Reset mid-operation discards all contents. No credits are returned for discarded flits.
- Read accept: rd_acc = rd_en && rd_vc < NUM_VCS && !vc_empty[rd_vc].
- Write accept: wr_accept = wr_en && wr_vc < NUM_VCS && (!vc_full[wr_vc] || (rd_acc && rd_vc == wr_vc)).
  - A write into a full VC is allowed when a read from the same VC is accepted in the same cycle.
- Empty VC, simultaneous write and read to that VC: no bypass. The read is rejected and the write is accepted. The flit becomes visible on rd_data the next cycle.
- Count update per VC: count_next = count + w - r, with w and r the accept terms for that VC. Read and write on different VCs update independently.
- Accepted write: flit is stored at wr_ptr and wr_ptr advances. Accepted read: rd_ptr advances.
- rd_data is combinational from rd_ptr of rd_vc and reflects writes from earlier cycles only.
- Latency: a flit written in cycle N is readable in cycle N+1.
- Out-of-range VC select (index >= NUM_VCS): request ignored, rd_valid = 0, rd_data = 0, no state change.
- credit_rtn: on rd_acc in cycle N, bit rd_vc is 1 in cycle N+1 only. Otherwise 0.
- Rejected requests never corrupt state.

Optional Feature:
- Macro: NEBULA_VCBUF_ERR_STATUS_EN.
- Defined:
  - err_ovf[v] sets on wr_en && wr_vc==v && !wr_accept while v is full.
  - err_udf[v] sets on rd_en && rd_vc==v while v is empty.
  - Both flags are sticky until err_clr=1 or reset.
  - If err_clr and a new set event occur in the same cycle, set wins.
- Not defined: err_ovf and err_udf are tied to 0, err_clr is ignored, and no error logic is instantiated. Ports remain present in both cases.

Test Plan:
- Reset, then write 4 flits 0xA0..0xA3 to VC2 -> vc_full[2]=1, vc_count VC2=4; a further write of 0xA4 gives wr_accept=0 and, with the macro defined, err_ovf[2]=1.
- Read VC2 four times -> rd_data 0xA0, 0xA1, 0xA2, 0xA3 in order; credit_rtn=4'b0100 one cycle after each read; then vc_empty[2]=1 and rd_data=0.
- Fill VC1 to full, then same-cycle read VC1 and write 0xB9 to VC1 -> wr_accept=1, count stays 4, 0xB9 is read last.
- Empty VC0, same-cycle write 0xC0 and read VC0 -> read rejected (with the macro, err_udf[0]=1); next cycle rd_valid=1, rd_data=0xC0.
- Interleave 10 writes to VC3 with reads, crossing pointer wrap twice, while writing VC0 and reading VC3 in the same cycles -> VC3 data stays in order and VC0 count is independent.
- Assert rst for 1 cycle with VC1 holding 3 flits -> all counts 0 immediately (asynchronous), no credit pulses, err flags cleared.
